// File: rtl/disk_ii_ctrl.sv
// Disk II floppy controller: soft switches, quarter-track head stepper, byte timing
// against an external track RAM, and the CPU-facing read/write/sense latches.
module disk_ii_ctrl #(
  parameter int unsigned NUM_DRIVES      = 2,
  parameter int unsigned TRACK_BYTES     = 6656,
  parameter int unsigned BYTE_CYCLES     = 32,
  parameter int unsigned STEP_CYCLES     = 1024,
  parameter int unsigned MAX_QPHASE      = 139,
  parameter int unsigned MOTOR_OFF_DELAY = 1000000
) (
  input  logic                  Clock_14MHz,
  input  logic                  reset,
  input  logic                  pre_phase0,
  input  logic                  device_select,
  input  logic                  io_select,
  input  logic [15:0]           addr,
  input  logic [7:0]            data_in,
  input  logic [7:0]            rom_data,
  input  logic [7:0]            trk_rdata,
  input  logic [NUM_DRIVES-1:0] write_protect,
  input  logic [NUM_DRIVES-1:0] dirty_clear,
  output logic [7:0]            data_out,
  output logic [5:0]            track,
  output logic [13:0]           track_addr,
  output logic                  trk_we,
  output logic [7:0]            trk_wdata,
  output logic [NUM_DRIVES-1:0] drive_on,
  output logic [3:0]            motor_phase,
  output logic [NUM_DRIVES-1:0] track_dirty
);

  localparam logic [13:0] ADDR_LAST = 14'(TRACK_BYTES - 32'd1);
  localparam logic [5:0]  BYTE_LAST = 6'(BYTE_CYCLES - 32'd1);
  localparam logic [15:0] STEP_LIM  = 16'(STEP_CYCLES);
  localparam logic [7:0]  QMAX      = 8'(MAX_QPHASE);
  localparam logic [19:0] OFF_LOAD  = 20'(MOTOR_OFF_DELAY);

  logic [3:0]            phase_r;
  logic                  motor_r;
  logic [19:0]           off_cnt_r;
  logic                  sel_r;
  logic                  q6_r;
  logic                  q7_r;
  logic [7:0]            qphase_r;
  logic                  powered_r;
  logic [15:0]           step_cnt_r;
  logic [5:0]            byte_cnt_r;
  logic [13:0]           addr_r;
  logic                  wrap_r;
  logic                  adv_r;
  logic                  valid_r;
  logic                  we_r;
  logic [7:0]            rd_latch_r;
  logic [7:0]            wr_latch_r;
  logic [7:0]            wdata_r;
  logic [NUM_DRIVES-1:0] drive_r;
  logic [NUM_DRIVES-1:0] dirty_r;

  logic                  acc_s;
  logic [3:0]            sw_s;
  logic                  motor_nxt_s;
  logic                  sel_nxt_s;
  logic [19:0]           off_nxt_s;
  logic [1:0]            p1_s;
  logic [1:0]            p3_s;
  logic                  up_s;
  logic                  down_s;
  logic                  step_ok_s;
  logic                  inc_s;
  logic                  dec_s;
  logic                  wrap_s;
  logic                  write_s;
  logic [NUM_DRIVES-1:0] drive_nxt_s;
  logic [NUM_DRIVES-1:0] dirty_set_s;
  logic                  unused_addr_s;

  assign acc_s         = device_select & pre_phase0;
  assign sw_s          = addr[3:0];
  assign unused_addr_s = ^addr[15:4];

  // Motor on/off-delay and drive-select next state; drive_on follows them in the same edge.
  always_comb begin
    motor_nxt_s = motor_r;
    off_nxt_s   = off_cnt_r;
    sel_nxt_s   = sel_r;
    drive_nxt_s = {NUM_DRIVES{1'b0}};
    if (acc_s && (sw_s == 4'h9)) begin
      motor_nxt_s = 1'b1;
      off_nxt_s   = 20'd0;
    end else if (acc_s && (sw_s == 4'h8)) begin
      off_nxt_s = OFF_LOAD;
      if (OFF_LOAD == 20'd0) motor_nxt_s = 1'b0;
      else motor_nxt_s = motor_r;
    end else if (pre_phase0 && (off_cnt_r != 20'd0)) begin
      off_nxt_s = off_cnt_r - 20'd1;
      if (off_cnt_r == 20'd1) motor_nxt_s = 1'b0;
      else motor_nxt_s = motor_r;
    end else begin
      off_nxt_s = off_cnt_r;
    end
    if (acc_s && (sw_s == 4'hA)) sel_nxt_s = 1'b0;
    else if (acc_s && (sw_s == 4'hB) && (NUM_DRIVES > 32'd1)) sel_nxt_s = 1'b1;
    else sel_nxt_s = sel_r;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      drive_nxt_s[i] = motor_nxt_s & (sel_nxt_s == i[0]);
    end
  end

  // Head-step direction, byte-timer wrap and write-pulse decisions.
  always_comb begin
    p1_s        = qphase_r[2:1] + 2'd1;
    p3_s        = qphase_r[2:1] + 2'd3;
    up_s        = phase_r[p1_s] & ~phase_r[p3_s];
    down_s      = phase_r[p3_s] & ~phase_r[p1_s];
    step_ok_s   = motor_r & pre_phase0 & (step_cnt_r >= STEP_LIM);
    inc_s       = step_ok_s & up_s & (qphase_r < QMAX);
    dec_s       = step_ok_s & down_s & (qphase_r != 8'd0);
    wrap_s      = motor_r & pre_phase0 & (byte_cnt_r == BYTE_LAST);
    write_s     = wrap_s & q7_r & ~write_protect[sel_r];
    dirty_set_s = {NUM_DRIVES{1'b0}};
    for (int i = 0; i < NUM_DRIVES; i++) begin
      dirty_set_s[i] = write_s & (sel_r == i[0]);
    end
  end

  // Controller state; the track address advances one clock after a wrap so the
  // write pulse sees the address of the byte just completed.
  always_ff @(posedge Clock_14MHz) begin
    if (reset) begin
      phase_r    <= 4'd0;
      motor_r    <= 1'b0;
      off_cnt_r  <= 20'd0;
      sel_r      <= 1'b0;
      drive_r    <= {NUM_DRIVES{1'b0}};
      q6_r       <= 1'b0;
      q7_r       <= 1'b0;
      step_cnt_r <= 16'd0;
      byte_cnt_r <= 6'd0;
      wrap_r     <= 1'b0;
      addr_r     <= 14'd0;
      adv_r      <= 1'b0;
      rd_latch_r <= 8'd0;
      valid_r    <= 1'b0;
      wr_latch_r <= 8'd0;
      we_r       <= 1'b0;
      wdata_r    <= 8'd0;
      dirty_r    <= {NUM_DRIVES{1'b0}};
    end else begin
      if (acc_s && (sw_s[3] == 1'b0)) phase_r[sw_s[2:1]] <= sw_s[0];
      motor_r   <= motor_nxt_s;
      off_cnt_r <= off_nxt_s;
      sel_r     <= sel_nxt_s;
      drive_r   <= drive_nxt_s;
      if (acc_s && (sw_s[3:1] == 3'b110)) q6_r <= sw_s[0];
      if (acc_s && (sw_s[3:1] == 3'b111)) q7_r <= sw_s[0];
      if (inc_s || dec_s) step_cnt_r <= 16'd1;
      else if (pre_phase0 && (step_cnt_r < STEP_LIM)) step_cnt_r <= step_cnt_r + 16'd1;
      if (wrap_s) byte_cnt_r <= 6'd0;
      else if (motor_r && pre_phase0) byte_cnt_r <= byte_cnt_r + 6'd1;
      wrap_r <= wrap_s;
      if (wrap_r) addr_r <= (addr_r == ADDR_LAST) ? 14'd0 : addr_r + 14'd1;
      adv_r <= wrap_r;
      if (adv_r && !q7_r) begin
        rd_latch_r <= trk_rdata;
        valid_r    <= 1'b1;
      end else if (acc_s && (sw_s == 4'hC) && !q7_r) begin
        valid_r <= 1'b0;
      end
      if (acc_s && (sw_s == 4'hF)) wr_latch_r <= data_in;
      we_r <= write_s;
      if (write_s) wdata_r <= wr_latch_r;
      dirty_r <= dirty_set_s | (dirty_r & ~dirty_clear);
    end
  end

  // Head position survives reset; only the very first clock after power-up clears it.
  always_ff @(posedge Clock_14MHz) begin
    powered_r <= 1'b1;
    if (!powered_r) qphase_r <= 8'd0;
    else if (!reset && inc_s) qphase_r <= qphase_r + 8'd1;
    else if (!reset && dec_s) qphase_r <= qphase_r - 8'd1;
  end

  // CPU read mux, using the Q6/Q7 state from before this access.
  always_comb begin
    data_out = 8'h00;
    if (io_select) data_out = rom_data;
    else if (device_select && !q7_r && (sw_s == 4'hC)) data_out = valid_r ? rd_latch_r : 8'h00;
    else if (device_select && q6_r && !q7_r && (sw_s == 4'hE)) data_out = {write_protect[sel_r], 7'b0000000};
    else data_out = 8'h00;
  end

  assign track       = qphase_r[7:2];
  assign track_addr  = addr_r;
  assign trk_we      = we_r & ~reset;
  assign trk_wdata   = wdata_r;
  assign drive_on    = drive_r;
  assign motor_phase = phase_r;
  assign track_dirty = dirty_r;

endmodule

// File: tb/tb_disk_ii_ctrl.sv
// Directed bench for disk_ii_ctrl with small timing parameters so every
// byte, step, wrap and motor-off boundary is reached in a few hundred clocks.
module tb_disk_ii_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pre_phase0;
  logic        device_select;
  logic        io_select;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  rom_data;
  logic [7:0]  trk_rdata;
  logic [1:0]  write_protect;
  logic [1:0]  dirty_clear;
  logic [7:0]  data_out;
  logic [5:0]  track;
  logic [13:0] track_addr;
  logic        trk_we;
  logic [7:0]  trk_wdata;
  logic [1:0]  drive_on;
  logic [3:0]  motor_phase;
  logic [1:0]  track_dirty;

  int          n_checks = 0;
  int          n_fail = 0;
  int          we_cnt = 0;
  logic [7:0]  we_data = 8'h00;
  logic [13:0] we_addr = 14'd0;
  logic [7:0]  d;

  disk_ii_ctrl #(
    .NUM_DRIVES(2), .TRACK_BYTES(5), .BYTE_CYCLES(4),
    .STEP_CYCLES(3), .MAX_QPHASE(7), .MOTOR_OFF_DELAY(4)
  ) dut (
    .Clock_14MHz(clk), .reset(reset), .pre_phase0(pre_phase0),
    .device_select(device_select), .io_select(io_select), .addr(addr),
    .data_in(data_in), .rom_data(rom_data), .trk_rdata(trk_rdata),
    .write_protect(write_protect), .dirty_clear(dirty_clear),
    .data_out(data_out), .track(track), .track_addr(track_addr),
    .trk_we(trk_we), .trk_wdata(trk_wdata), .drive_on(drive_on),
    .motor_phase(motor_phase), .track_dirty(track_dirty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (trk_we) begin
      we_cnt  = we_cnt + 1;
      we_data = trk_wdata;
      we_addr = track_addr;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int n);
    pre_phase0 = 1'b1;
    repeat (n) tick();
    pre_phase0 = 1'b0;
  endtask

  task automatic sw(input logic [3:0] a);
    addr = {12'hC0E, a};
    device_select = 1'b1;
    pre_phase0 = 1'b1;
    tick();
    device_select = 1'b0;
    pre_phase0 = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    addr = {12'hC0E, a};
    device_select = 1'b1;
    pre_phase0 = 1'b1;
    #2;
    v = data_out;
    tick();
    device_select = 1'b0;
    pre_phase0 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pre_phase0 = 1'b0; device_select = 1'b0; io_select = 1'b0;
    addr = 16'h0000; data_in = 8'h00; rom_data = 8'h00; trk_rdata = 8'hD5;
    write_protect = 2'b00; dirty_clear = 2'b00;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check_eq("rst_drive_on", 32'(drive_on), 32'd0);
    check_eq("rst_motor_phase", 32'(motor_phase), 32'd0);
    check_eq("rst_track", 32'(track), 32'd0);
    check_eq("rst_track_addr", 32'(track_addr), 32'd0);
    check_eq("rst_trk_we", 32'(trk_we), 32'd0);
    check_eq("rst_dirty", 32'(track_dirty), 32'd0);
    check_eq("rst_data_out", 32'(data_out), 32'd0);

    // Read path: two byte periods, then the latched byte is handed out once.
    sw(4'h9);
    check_eq("motor_on", 32'(drive_on), 32'd1);
    strobes(8);
    tick();
    check_eq("rd_addr2", 32'(track_addr), 32'd2);
    tick();
    rd(4'hC, d);
    check_eq("rd_byte", 32'(d), 32'hD5);
    rd(4'hC, d);
    check_eq("rd_reread", 32'(d), 32'h00);

    // Track address wrap at TRACK_BYTES-1.
    strobes(2);
    tick();
    check_eq("addr3", 32'(track_addr), 32'd3);
    strobes(4);
    tick();
    check_eq("addr_last", 32'(track_addr), 32'd4);
    strobes(4);
    tick();
    check_eq("addr_wrap", 32'(track_addr), 32'd0);

    // Sense mode and drive select.
    sw(4'hD);
    write_protect = 2'b01;
    rd(4'hE, d);
    check_eq("sense_wp0", 32'(d), 32'h80);
    write_protect = 2'b00;
    rd(4'hE, d);
    check_eq("sense_nowp", 32'(d), 32'h00);
    sw(4'hB);
    check_eq("sel_move", 32'(drive_on), 32'd2);
    write_protect = 2'b10;
    rd(4'hE, d);
    check_eq("sense_wp1", 32'(d), 32'h80);
    write_protect = 2'b00;
    sw(4'hA);
    sw(4'hC);
    check_eq("no_we_read", 32'(we_cnt), 32'd0);

    // Head stepping with saturation at MAX_QPHASE (7), then reset holds the track.
    sw(4'h3);
    strobes(10);
    check_eq("step_q2", 32'(track), 32'd0);
    sw(4'h2);
    sw(4'h5);
    check_eq("phase_state", 32'(motor_phase), 32'h4);
    strobes(10);
    check_eq("step_q4", 32'(track), 32'd1);
    sw(4'h4);
    sw(4'h7);
    strobes(10);
    sw(4'h6);
    sw(4'h1);
    strobes(10);
    check_eq("step_sat", 32'(track), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rst_outs", {track_addr, trk_we, trk_wdata, drive_on, motor_phase, track_dirty, data_out}, 32'd0);
    check_eq("rst_track_hold", 32'(track), 32'd1);
    reset = 1'b0;
    sw(4'h9);
    sw(4'h5);
    strobes(10);
    sw(4'h4);
    sw(4'h3);
    strobes(10);
    check_eq("step_down", 32'(track), 32'd0);

    // Write path, protection, dirty flag set/clear priority, reset mid-write.
    do_reset();
    sw(4'h9);
    data_in = 8'hFF;
    sw(4'hF);
    strobes(3);
    tick();
    tick();
    check_eq("we_count1", 32'(we_cnt), 32'd1);
    check_eq("we_data", 32'(we_data), 32'hFF);
    check_eq("we_addr", 32'(we_addr), 32'd0);
    check_eq("dirty_set", 32'(track_dirty), 32'd1);
    check_eq("we_adv", 32'(track_addr), 32'd1);
    dirty_clear = 2'b01;
    tick();
    dirty_clear = 2'b00;
    check_eq("dirty_clr", 32'(track_dirty), 32'd0);
    write_protect = 2'b01;
    strobes(4);
    tick();
    tick();
    check_eq("we_protected", 32'(we_cnt), 32'd1);
    check_eq("dirty_protected", 32'(track_dirty), 32'd0);
    write_protect = 2'b00;
    dirty_clear = 2'b01;
    strobes(4);
    dirty_clear = 2'b00;
    tick();
    tick();
    check_eq("we_count2", 32'(we_cnt), 32'd2);
    check_eq("dirty_prio", 32'(track_dirty), 32'd1);
    sw(4'hB);
    check_eq("sel_drive1", 32'(drive_on), 32'd2);
    strobes(2);
    pre_phase0 = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pre_phase0 = 1'b0;
    tick();
    tick();
    check_eq("rst_no_we", 32'(we_cnt), 32'd2);

    // Motor off delay of 4 strobes, and a $9 during the delay cancelling it.
    do_reset();
    sw(4'h9);
    check_eq("off_on", 32'(drive_on), 32'd1);
    sw(4'h8);
    check_eq("off_s0", 32'(drive_on), 32'd1);
    strobes(3);
    check_eq("off_s3", 32'(drive_on), 32'd1);
    strobes(1);
    check_eq("off_s4", 32'(drive_on), 32'd0);
    tick();
    strobes(8);
    tick();
    check_eq("byte_frozen", 32'(track_addr), 32'd1);
    sw(4'h9);
    sw(4'h8);
    strobes(1);
    sw(4'h9);
    strobes(6);
    check_eq("on_keep", 32'(drive_on), 32'd1);

    // ROM window has priority over the soft-switch read path.
    io_select = 1'b1;
    device_select = 1'b1;
    addr = 16'hC0EC;
    rom_data = 8'hA5;
    #2;
    check_eq("rom_prio", 32'(data_out), 32'hA5);
    device_select = 1'b0;
    rom_data = 8'h3C;
    #2;
    check_eq("rom_only", 32'(data_out), 32'h3C);
    io_select = 1'b0;
    #2;
    check_eq("idle_out", 32'(data_out), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disk_ii_ctrl.md
DISK_II_CTRL -- requirements
Module: disk_ii_ctrl

Interface
REQ-001 Parameters (one per line: name, default, meaning):
- NUM_DRIVES, 2, number of drives, legal 1..2
- TRACK_BYTES, 6656, bytes per track, wrap point of track_addr, legal 2..16384
- BYTE_CYCLES, 32, pre_phase0 strobes per disk byte, legal 2..63
- STEP_CYCLES, 1024, minimum pre_phase0 strobes between head quarter-steps, legal 1..65535
- MAX_QPHASE, 139, highest quarter-track head position (35 tracks)
- MOTOR_OFF_DELAY, 1000000, pre_phase0 strobes the motor stays on after an off command, legal 0..2^20-1
REQ-002 Ports (name, direction, width, meaning):
- Clock_14MHz, in, 1, the only clock
- reset, in, 1, synchronous, active-high
- pre_phase0, in, 1, one-clock CPU-cycle strobe
- device_select, in, 1, $C0n0-$C0nF access
- io_select, in, 1, $CnXX ROM access
- addr, in, 16, CPU address
- data_in, in, 8, CPU write data
- rom_data, in, 8, external boot ROM data
- trk_rdata, in, 8, external track RAM read data, one clock latency from track_addr
- write_protect, in, NUM_DRIVES, per-drive write-protect
- dirty_clear, in, NUM_DRIVES, per-drive dirty clear strobe
- data_out, out, 8, CPU read data
- track, out, 6, current track = qphase[7:2]
- track_addr, out, 14, byte address within track
- trk_we, out, 1, one-clock track RAM write strobe
- trk_wdata, out, 8, track RAM write data
- drive_on, out, NUM_DRIVES, one-hot spinning drive
- motor_phase, out, 4, stepper magnet state
- track_dirty, out, NUM_DRIVES, per-drive written-since-clear flag
REQ-003 Clocking and reset SHALL be as follows: one clock, Clock_14MHz; reset is synchronous and active-high. All state SHALL update only on Clock_14MHz rising edges; soft-switch and counter actions SHALL be qualified by pre_phase0.

Function
REQ-004 A soft-switch access SHALL be device_select & pre_phase0, decoded on addr[3:0]:
- 0-7: motor_phase[addr[2:1]] <= addr[0]
- 8: motor off request; 9: motor on
- A/B: drive select 0/1 (B ignored when NUM_DRIVES=1)
- C/D: Q6 <= addr[0]; E/F: Q7 <= addr[0]
REQ-005 Motor SHALL follow this behaviour:
- $9 sets motor on and clears the off-delay counter.
- $8 loads the counter with MOTOR_OFF_DELAY, which decrements per pre_phase0; motor clears when it reaches 0 (immediately if the delay is 0).
- drive_on = motor ? onehot(sel) : 0.
- A select change while the motor is on SHALL move drive_on in the next clock.
REQ-006 Head position qphase SHALL be an 8-bit quarter-track position, p = qphase[2:1].
- Rule: if motor_phase[(p+1)%4] & ~motor_phase[(p+3)%4] then +1; if the reverse then -1; else hold.
- Moves SHALL occur only while the motor is on, at most one per STEP_CYCLES pre_phase0 strobes.
- The position SHALL saturate at 0 and MAX_QPHASE.
REQ-007 The byte timer SHALL count pre_phase0 strobes while the motor is on and freeze while it is off.
- On reaching BYTE_CYCLES-1 it SHALL wrap to 0 and advance track_addr.
- track_addr wraps from TRACK_BYTES-1 to 0.
- A track change SHALL NOT reset track_addr.
REQ-008 Read mode is Q7=0.
- One clock after each track_addr advance, rd_latch <= trk_rdata and valid <= 1.
- A CPU read of $C0nC with valid=1 returns rd_latch and clears valid at that access; with valid=0 it returns 8'h00.
REQ-009 Sense mode is Q6=1, Q7=0: a read of $C0nE SHALL return {write_protect[sel], 7'b0}.
REQ-010 Write mode is Q7=1.
- A CPU access to $C0nF with pre_phase0 loads wr_latch <= data_in.
- At each byte-timer wrap, if the motor is on and ~write_protect[sel], trk_we pulses one clock with trk_wdata=wr_latch at the pre-advance track_addr.
- track_dirty[sel] SHALL set in the same clock.
REQ-011 dirty_clear[i] SHALL clear track_dirty[i]. A simultaneous set for the same drive SHALL take priority over the clear.
REQ-012 data_out SHALL be:
- rom_data when io_select (io_select has priority);
- otherwise per REQ-008/009;
- otherwise 8'h00.
data_out SHALL use Q6/Q7 values from before the current access.
REQ-013 Arithmetic SHALL be unsigned with explicit saturation or wrap. There SHALL be no signed integer intermediates.

Reset
REQ-014 Reset SHALL set motor_phase, drive_on, track_addr, trk_we, track_dirty, Q6, Q7, sel, valid, rd_latch, wr_latch and all counters to 0. Reset SHALL leave qphase unchanged (head position survives reset) except on the first power-up, where qphase initialises to 0.
REQ-015 Reset asserted mid-write SHALL suppress any trk_we pulse in that clock.

Verification
REQ-016 Motor on, phases stepped 0->1->2->3 with more than STEP_CYCLES strobes each, starting at qphase=0 -> track 0->1 after qphase reaches 4, no move beyond 139.
REQ-017 Motor on, Q7=0, 2*BYTE_CYCLES strobes, trk_rdata=8'hD5 -> track_addr=2; $C0nC read returns 8'hD5, then 8'h00 on re-read before the next byte.
REQ-018 track_addr=TRACK_BYTES-1, one byte period -> track_addr=0.
REQ-019 Q7=1, data_in=8'hFF on $C0nF, write_protect=0 -> one trk_we with trk_wdata=8'hFF and track_dirty[0]=1; repeat with write_protect=1 -> no trk_we.
REQ-020 $C0n8 with MOTOR_OFF_DELAY=4 -> drive_on stays on for 4 strobes then clears; a $C0n9 at strobe 2 keeps it on.
REQ-021 io_select with device_select -> data_out=rom_data; reset during motor on -> all outputs 0 except track, which holds.
